// File: rtl/axi_pkg.sv
// Shared AXI3 encodings and channel FSM state types for the register-file secondary.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  // Only FIXED and INCR are served; WRAP and the reserved encoding are errors.
  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == FIXED) || (burst == INCR);
  endfunction

endpackage

// File: rtl/axi_reg_bank.sv
// Register storage with byte-strobe merge, read-only masking, flat export and per-register write strobes.
module axi_reg_bank
  import axi_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
  parameter int                  BANK_AW    = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [BANK_AW-1:0]             wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [BANK_AW-1:0]             rd_addr,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;
  logic [NUM_REGS-1:0]   wr_pulse_d;

  // Merge enabled bytes into the addressed register unless it is read-only.
  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (wr_en && !RO_MASK[wr_addr]) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wr_strb[b]) begin
          regs_d[wr_addr][b*8 +: 8] = wr_data[b*8 +: 8];
        end
      end
      wr_pulse_d[wr_addr] = 1'b1;
    end
  end

  // Register state and the one-cycle write strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  // Read port sees pre-write contents, so a same-cycle read returns the old value.
  assign rd_data    = regs_q[rd_addr];
  assign wr_pulse_o = wr_pulse_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_export
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

endmodule

// File: rtl/axi_regfile_secondary.sv
// AXI3 CSR secondary: independent write/read FSMs in front of a parametrised register bank.
module axi_regfile_secondary
  import axi_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 12,
  parameter int                  ID_WIDTH   = 4,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ID_WIDTH-1:0]            awid,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [3:0]                     awlen,
  input  logic [2:0]                     awsize,
  input  logic [1:0]                     awburst,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [ID_WIDTH-1:0]            wid,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wlast,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [ID_WIDTH-1:0]            bid,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ID_WIDTH-1:0]            arid,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [3:0]                     arlen,
  input  logic [2:0]                     arsize,
  input  logic [1:0]                     arburst,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [ID_WIDTH-1:0]            rid,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rlast,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int SIZE_LOG = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W    = ADDR_WIDTH - SIZE_LOG;
  localparam int BANK_AW  = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] NUM_REGS_IDX = IDX_W'(NUM_REGS);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  // Write channel state
  wr_state_t           w_state_q, w_state_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [IDX_W-1:0]    w_idx_q, w_idx_d;
  logic [3:0]          w_len_q, w_len_d;
  logic [3:0]          w_cnt_q, w_cnt_d;
  logic                w_fixed_q, w_fixed_d;
  logic                w_cmd_err_q, w_cmd_err_d;
  logic                w_resp_err_q, w_resp_err_d;
  logic                w_beat_err, w_last_beat, bank_wr_en;

  // Read channel state
  rd_state_t             r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [3:0]            r_len_q, r_len_d;
  logic [3:0]            r_cnt_q, r_cnt_d;
  logic                  r_fixed_q, r_fixed_d;
  logic                  r_cmd_err_q, r_cmd_err_d;
  logic                  rd_load, rd_clear, rd_cmd_err, rd_beat_err;
  logic [IDX_W-1:0]      rd_idx;
  logic [DATA_WIDTH-1:0] bank_rd_data;

  // wid is meaningless without interleaving; the low address bits only select bytes.
  logic unused_inputs;
  assign unused_inputs = ^{wid, awaddr[SIZE_LOG-1:0], araddr[SIZE_LOG-1:0]};

  // Write FSM: latch AW, apply one beat per W handshake, then hold the response until bready.
  always_comb begin
    w_state_d    = w_state_q;
    awready_d    = awready_q;
    wready_d     = wready_q;
    bvalid_d     = bvalid_q;
    bid_d        = bid_q;
    bresp_d      = bresp_q;
    w_id_d       = w_id_q;
    w_idx_d      = w_idx_q;
    w_len_d      = w_len_q;
    w_cnt_d      = w_cnt_q;
    w_fixed_d    = w_fixed_q;
    w_cmd_err_d  = w_cmd_err_q;
    w_resp_err_d = w_resp_err_q;
    w_beat_err   = 1'b0;
    w_last_beat  = 1'b0;
    bank_wr_en   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          w_id_d       = awid;
          w_idx_d      = awaddr[ADDR_WIDTH-1:SIZE_LOG];
          w_len_d      = awlen;
          w_cnt_d      = '0;
          w_fixed_d    = (awburst == FIXED);
          w_cmd_err_d  = (awsize != 3'(SIZE_LOG)) || !burst_supported(awburst);
          w_resp_err_d = 1'b0;
          w_state_d    = W_DATA;
          awready_d    = 1'b0;
          wready_d     = 1'b1;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          w_beat_err   = w_cmd_err_q || (w_idx_q >= NUM_REGS_IDX);
          w_last_beat  = (w_cnt_q == w_len_q);
          bank_wr_en   = !w_beat_err;
          w_resp_err_d = w_resp_err_q || w_beat_err || (wlast != w_last_beat);
          w_cnt_d      = w_cnt_q + 4'd1;
          if (!w_fixed_q) begin
            w_idx_d = w_idx_q + IDX_ONE;
          end
          if (w_last_beat) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = w_id_q;
            bresp_d   = w_resp_err_d ? SLVERR : OKAY;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        awready_d = 1'b1;
        wready_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Write channel registers; reset abandons any burst without a response.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q    <= W_IDLE;
      awready_q    <= 1'b1;
      wready_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      bid_q        <= '0;
      bresp_q      <= '0;
      w_id_q       <= '0;
      w_idx_q      <= '0;
      w_len_q      <= '0;
      w_cnt_q      <= '0;
      w_fixed_q    <= 1'b0;
      w_cmd_err_q  <= 1'b0;
      w_resp_err_q <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      awready_q    <= awready_d;
      wready_q     <= wready_d;
      bvalid_q     <= bvalid_d;
      bid_q        <= bid_d;
      bresp_q      <= bresp_d;
      w_id_q       <= w_id_d;
      w_idx_q      <= w_idx_d;
      w_len_q      <= w_len_d;
      w_cnt_q      <= w_cnt_d;
      w_fixed_q    <= w_fixed_d;
      w_cmd_err_q  <= w_cmd_err_d;
      w_resp_err_q <= w_resp_err_d;
    end
  end

  // Read FSM control: pick which index to load into the output register this cycle.
  always_comb begin
    r_state_d   = r_state_q;
    arready_d   = arready_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rid_d       = rid_q;
    r_idx_d     = r_idx_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_fixed_d   = r_fixed_q;
    r_cmd_err_d = r_cmd_err_q;
    rd_load     = 1'b0;
    rd_clear    = 1'b0;
    rd_idx      = r_idx_q;
    rd_cmd_err  = r_cmd_err_q;
    case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          rid_d       = arid;
          r_idx_d     = araddr[ADDR_WIDTH-1:SIZE_LOG];
          r_len_d     = arlen;
          r_cnt_d     = '0;
          r_fixed_d   = (arburst == FIXED);
          r_cmd_err_d = (arsize != 3'(SIZE_LOG)) || !burst_supported(arburst);
          r_state_d   = R_DATA;
          arready_d   = 1'b0;
          rvalid_d    = 1'b1;
          rlast_d     = (arlen == 4'd0);
          rd_load     = 1'b1;
          rd_idx      = r_idx_d;
          rd_cmd_err  = r_cmd_err_d;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (r_cnt_q == r_len_q) begin
            r_state_d = R_IDLE;
            arready_d = 1'b1;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rd_clear  = 1'b1;
          end else begin
            r_cnt_d = r_cnt_q + 4'd1;
            if (!r_fixed_q) begin
              r_idx_d = r_idx_q + IDX_ONE;
            end
            rlast_d = (r_cnt_d == r_len_q);
            rd_load = 1'b1;
            rd_idx  = r_idx_d;
          end
        end
      end
      default: begin
        r_state_d = R_IDLE;
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
      end
    endcase
  end

  // Read data path: sample the bank for the chosen index, zeroing error beats.
  always_comb begin
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rd_beat_err = 1'b0;
    if (rd_load) begin
      rd_beat_err = rd_cmd_err || (rd_idx >= NUM_REGS_IDX);
      rdata_d     = rd_beat_err ? '0 : bank_rd_data;
      rresp_d     = rd_beat_err ? SLVERR : OKAY;
    end else if (rd_clear) begin
      rdata_d = '0;
      rresp_d = OKAY;
    end
  end

  // Read channel registers; data and response hold while the beat is stalled.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q   <= R_IDLE;
      arready_q   <= 1'b1;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      r_idx_q     <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      r_fixed_q   <= 1'b0;
      r_cmd_err_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rid_q       <= rid_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      r_idx_q     <= r_idx_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      r_fixed_q   <= r_fixed_d;
      r_cmd_err_q <= r_cmd_err_d;
    end
  end

  axi_reg_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK),
    .BANK_AW    (BANK_AW)
  ) u_bank (
    .clk        (aclk),
    .rst        (areset),
    .wr_en      (bank_wr_en),
    .wr_addr    (w_idx_q[BANK_AW-1:0]),
    .wr_data    (wdata),
    .wr_strb    (wstrb),
    .rd_addr    (rd_idx[BANK_AW-1:0]),
    .rd_data    (bank_rd_data),
    .regs_o     (regs_o),
    .wr_pulse_o (wr_pulse_o)
  );

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rid     = rid_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule
